// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside the E-stage ALU; owns HI/LO.
// Latency: mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES; mthi/mtlo write in one edge.
// Backpressure: stall_md holds an md-class D-stage instruction while busy or while one is starting.
// Ports: clk/reset (sync, active-low), start/md_op/a/b from E, md_use_D from D,
//        hi/lo architectural registers, busy, stall_md (combinational).
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;

  // Arithmetic for all four long ops, evaluated in the start cycle.
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag;
  logic [31:0] divu_q, divu_r, div_q, div_r;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    // Guarded divisor keeps the divider defined; a zero-divisor result is discarded anyway.
    b_safe = (b == 32'd0) ? 32'd1 : b;
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b[31] ? (~b_safe + 32'd1) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    divu_q = a / b_safe;
    divu_r = a % b_safe;
    // Sign-magnitude division: 0x80000000 / -1 naturally yields q=0x80000000, r=0.
    div_q  = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    div_r  = a[31] ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              case (md_op)
                3'd0:    {res_hi_d, res_lo_d} = prod_s;
                3'd1:    {res_hi_d, res_lo_d} = prod_u;
                3'd2:    {res_hi_d, res_lo_d} = {div_r, div_q};
                default: {res_hi_d, res_lo_d} = {divu_r, divu_q};
              endcase
              div0_d  = md_op[1] && (b == 32'd0);
              count_d = md_op[1] ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start here is a protocol violation and is deliberately ignored.
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          if (!div0_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign stall_md = md_use_D & (busy_q | (start & (md_op <= 3'd3)));

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        md_use_D;
  logic [31:0] hi, lo;
  logic        busy, stall_md;

  int n_checks = 0;
  int n_fail   = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .md_use_D(md_use_D), .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high (bounded), noting whether stall_md stayed high.
  task automatic wait_idle(output int cyc, output bit stall_ok);
    cyc = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      if (stall_md !== 1'b1) stall_ok = 1'b0;
      cyc++;
      tick();
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; md_op = op; a = va; b = vb;
    tick();
    start = 1'b0; md_op = 3'd7; a = 32'd0; b = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; md_use_D = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_md); end
  endtask

  task automatic test_mult();
    int cyc; bit ok;
    md_use_D = 1'b1;
    start = 1'b1; md_op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd5;
    #1;
    n_checks++; if (stall_md !== 1'b1) begin n_fail++; $display("FAIL mult_start_stall got=%b exp=1", stall_md); end
    tick();
    start = 1'b0; md_op = 3'd7;
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mult_no_forward got=%h exp=%h", hi, 32'd0); end
    wait_idle(cyc, ok);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mult_stall_while_busy got=%b exp=1", ok); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    n_checks++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL mult_stall_after got=%b exp=0", stall_md); end
  endtask

  task automatic test_div();
    int cyc; bit ok;
    launch(3'd3, 32'd7, 32'd2);
    wait_idle(cyc, ok);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divu_busy_cycles got=%0d exp=10", cyc); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi got=%h exp=1", hi); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got=%h exp=3", lo); end
    launch(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc, ok);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_busy_cycles got=%0d exp=10", cyc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc, ok);
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
  endtask

  task automatic test_mthi_mtlo();
    bit busy_seen;
    busy_seen = 1'b0;
    md_use_D = 1'b1;
    start = 1'b1; md_op = 3'd4; a = 32'h1234_5678;
    #1;
    n_checks++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got=%b exp=0", stall_md); end
    tick();
    if (busy !== 1'b0) busy_seen = 1'b1;
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    md_op = 3'd5; a = 32'h9ABC_DEF0;
    tick();
    if (busy !== 1'b0) busy_seen = 1'b1;
    start = 1'b0; md_op = 3'd7; a = 32'd0;
    n_checks++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
    tick();
    if (busy !== 1'b0) busy_seen = 1'b1;
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL mthi_mtlo_busy got=%b exp=0", busy_seen); end
  endtask

  task automatic test_div_zero();
    int cyc; bit ok;
    launch(3'd4, 32'h0000_AAAA, 32'd0);
    launch(3'd5, 32'h0000_5555, 32'd0);
    launch(3'd2, 32'd9, 32'd0);
    wait_idle(cyc, ok);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divz_busy_cycles got=%0d exp=10", cyc); end
    n_checks++; if (hi !== 32'h0000_AAAA) begin n_fail++; $display("FAIL divz_hi got=%h exp=0000aaaa", hi); end
    n_checks++; if (lo !== 32'h0000_5555) begin n_fail++; $display("FAIL divz_lo got=%h exp=00005555", lo); end
  endtask

  task automatic test_reset_mid();
    bit dirty;
    dirty = 1'b0;
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) dirty = 1'b1;
    end
    n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_write got=%b exp=0", dirty); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bit stalled;
    md_use_D = 1'b1;
    stalled = 1'b1;
    launch(3'd0, 32'd3, 32'd7);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      if (cyc == 2) begin
        start = 1'b1; md_op = 3'd0; a = 32'd100; b = 32'd100;
        #1;
        if (stall_md !== 1'b1) stalled = 1'b0;
      end else begin
        start = 1'b0; md_op = 3'd7; a = 32'd0; b = 32'd0;
      end
      cyc++;
      tick();
    end
    start = 1'b0;
    n_checks++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL busy_start_stall got=%b exp=1", stalled); end
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL busy_start_cycles got=%0d exp=5", cyc); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd21) begin n_fail++; $display("FAIL busy_start_result got=%h_%h exp=0_15", hi, lo); end
    launch(3'd6, 32'hDEAD_BEEF, 32'd1);
    n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd21) begin n_fail++; $display("FAIL reserved_op got=%b_%h_%h exp=0_0_15", busy, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_div_zero();
    test_reset_mid();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler that sits beside the E-stage ALU of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and sequences a fixed-latency multi-cycle operation.
- Owns the HI/LO registers.
- Raises a stall request that the hazard logic ORs into the D-stage Stall, so that no later mfhi/mflo/md instruction enters E while the unit is busy.

Parameters:
- MULT_CYCLES, 5, cycles busy for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, cycles busy for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset: reset==0 at a rising edge clears state
- start  in  1  E-stage holds a valid md-class instruction this cycle (one-cycle pulse per instruction)
- md_op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 reserved (treated as no-op)
- a  in  32  forwarded rs value (MFRSE)
- b  in  32  forwarded rt value (MFRTE)
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- hi  out  32  current HI register
- lo  out  32  current LO register
- busy  out  1  operation in flight
- stall_md  out  1  combinational: md_use_D & (busy | (start & md_op<=3))

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, count=0, hi=0, lo=0, busy=0, staging regs=0. This overrides any in-flight operation, whose result is discarded.
- States are IDLE and RUN.
- IDLE, start=1, md_op in 0..3:
  - Compute the 64-bit result from a, b into staging regs (res_hi, res_lo) at this edge.
  - Load count = CYC-1, where CYC = MULT_CYCLES for ops 0/1 and DIV_CYCLES for ops 2/3.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, md_op=4: hi<=a at this edge. md_op=5: lo<=a at this edge. Stay IDLE; busy stays 0.
- RUN:
  - Each edge with count!=0: count<=count-1.
  - Edge with count==0: hi<=res_hi, lo<=res_lo, state<=IDLE, busy<=0.
  - Result: busy is high exactly CYC cycles. The new HI/LO are visible in the same cycle busy falls.
- start while RUN is a protocol violation (prevented by stall_md). It is ignored: it does not restart the counter, alter the staging regs, or write hi/lo.
- Arithmetic:
  - mult: signed 32x32 giving 64 bits, with hi=[63:32] and lo=[31:0].
  - multu: unsigned 32x32 giving 64 bits.
  - div: lo=quotient truncated toward zero; hi=remainder, which takes the sign of the dividend a.
  - divu: unsigned quotient and remainder.
  - Division by zero (b==0, div/divu): the full busy latency is still consumed; at completion hi and lo keep their prior values.
  - Signed overflow case div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Reserved md_op values with start=1: no state change.
- stall_md is purely combinational. In the start cycle it is asserted if the D instruction is md-class. On the cycle busy falls it is 0 unless a new start occurs.
- hi/lo are read directly by the E-stage mfhi/mflo path. The unit does not forward in-flight results.

Test Plan:
- Reset, then mult with a=0xFFFFFFFD, b=5, CYC=5 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_md=1 during those cycles while md_use_D=1.
- divu a=7, b=2, then div a=0xFFFFFFF9 (-7), b=2 -> divu gives hi=1, lo=3 after 10 cycles; div gives hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo update on each respective edge; busy never rises.
- div by zero: hi=0xAAAA, lo=0x5555 preset, div a=9, b=0 -> busy 10 cycles; hi/lo unchanged afterwards.
- reset driven to 0 at cycle 3 of a multu 0xFFFFFFFF*0xFFFFFFFF -> next cycle busy=0 and hi=lo=0; the later completion edge writes nothing.
- start with md_op=0 injected while busy -> ignored; original result commits at the original cycle and count is unaffected. Also: md_use_D=1 with start=1 in IDLE -> stall_md=1 in the same cycle.
